// File: rtl/mux_rr_reg.sv
// Registered N:1 stream multiplexer with a one-entry output stage.
// Supports fixed-select or round-robin arbitration and counts output handshakes.
module mux_rr_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               xfer_count
);

    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      xfer_count_q, xfer_count_d;

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] cand_idx;
    logic             in_xfer;
    logic             out_xfer;
    int               cand;

    assign load_en  = !out_valid_q || out_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (!mode) begin
            if (int'(sel) < CHANNELS) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                cand     = (int'(last_grant_q) + k) % CHANNELS;
                cand_idx = SEL_W'(cand);
                if (!grant_vld && in_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!reset && load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign in_xfer = |(in_ready & in_valid);

    always_comb begin
        last_grant_d = last_grant_q;
        out_sel_d    = out_sel_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        xfer_count_d = xfer_count_q;
        if (out_xfer) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
        if (in_xfer) begin
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                last_grant_d = grant_idx;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SEL_W'(CHANNELS - 1);
            out_sel_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            out_sel_q    <= out_sel_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_sel    = out_sel_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: vector table, directed sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_mux_rr_reg;

    localparam int W = 8;
    localparam int C = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           mode;
    logic [S-1:0]   sel;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_sel;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    xfer_count;

    mux_rr_reg #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit       m_known = 0;
    bit       m_valid;
    int       m_data;
    int       m_sel;
    int       m_cnt;
    int       m_last;
    logic [C-1:0] smp_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the consumer-side rules allow this cycle, or -1.
    function automatic int model_grant();
        if (reset) return -1;
        if (m_valid && !out_ready) return -1;
        if (!mode) return (int'(sel) < C) ? int'(sel) : -1;
        for (int k = 1; k <= C; k++) begin
            int c = (m_last + k) % C;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        bit in_x, out_x;
        if (reset) begin
            m_known = 1; m_valid = 0; m_data = 0; m_sel = 0; m_cnt = 0; m_last = C - 1;
            return;
        end
        in_x  = (g >= 0) && in_valid[g];
        out_x = m_valid && out_ready;
        if (out_x) m_cnt = (m_cnt + 1) % 65536;
        if (in_x) begin
            m_data  = (in_data >> (g * W)) & 8'hFF;
            m_sel   = g;
            m_valid = 1;
            if (mode) m_last = g;
        end else if (out_x) begin
            m_valid = 0;
        end
    endtask

    // One clock: check everything at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int g;
        logic [C-1:0] exp_rdy;
        @(negedge clk);
        smp_ready = in_ready;
        g = model_grant();
        exp_rdy = (g >= 0) ? C'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), m_data);
            chk("out_sel", 32'(out_sel), m_sel);
            chk("xfer_count", 32'(xfer_count), m_cnt);
        end
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic         mode;
        logic [S-1:0] sel;
        logic [C-1:0] valid;
        logic [C-1:0] exp_ready;
        logic         exp_ovalid;
        logic [S-1:0] exp_osel;
        logic [W-1:0] exp_odata;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        vecs[0] = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2, 8'h32};
        vecs[1] = '{1'b0, 2'd1, 4'b0000, 4'b0010, 1'b0, 2'd0, 8'h00};
        vecs[2] = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0, 8'h10};
        vecs[3] = '{1'b1, 2'd3, 4'b1010, 4'b0010, 1'b1, 2'd1, 8'h21};
        vecs[4] = '{1'b1, 2'd0, 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h43};
        vecs[5] = '{1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[6] = '{1'b0, 2'd3, 4'b0001, 4'b1000, 1'b0, 2'd0, 8'h00};

        reset = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'b1111;
        in_data = 32'h43322110; out_ready = 1'b1;

        // Reset then idle
        cycle();
        chk("rst_in_ready", 32'(smp_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_xfer_count", 32'(xfer_count), 32'h0);
        reset = 1'b0;
        cycle();
        chk("post_rst_ready", 32'(smp_ready), 32'b0001);

        // Grant table from reset state
        foreach (vecs[i]) begin
            do_reset();
            mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].valid;
            cycle();
            chk("tbl_ready", 32'(smp_ready), 32'(vecs[i].exp_ready));
            chk("tbl_out_valid", 32'(out_valid), 32'(vecs[i].exp_ovalid));
            chk("tbl_out_sel", 32'(out_sel), 32'(vecs[i].exp_osel));
            chk("tbl_out_data", 32'(out_data), 32'(vecs[i].exp_odata));
        end

        // Fixed select
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
        cycle();
        chk("fix_ready", 32'(smp_ready), 32'b0100);
        chk("fix_data", 32'(out_data), 32'h32);
        chk("fix_sel", 32'(out_sel), 32'd2);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("fix_count", 32'(xfer_count), k);
        end

        // Round-robin fairness
        do_reset();
        mode = 1'b1; in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_out_sel", 32'(out_sel), k % 4);
        end
        chk("rr_count_8", 32'(xfer_count), 32'd7);
        in_valid = 4'b0000;
        cycle();
        chk("rr_count_9", 32'(xfer_count), 32'd8);

        // Sparse requests
        do_reset();
        mode = 1'b1; in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("sparse_ready_mask", 32'(smp_ready & 4'b0101), 32'h0);
            chk("sparse_sel", 32'(out_sel), (k % 2 == 0) ? 1 : 3);
        end

        // Backpressure
        do_reset();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1000;
        cycle();
        chk("bp_loaded", 32'(out_data), 32'h43);
        out_ready = 1'b0;
        saved = int'(xfer_count);
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom; in_valid = 4'($urandom); mode = 1'($urandom); sel = 2'($urandom);
            cycle();
            chk("bp_ready", 32'(smp_ready), 32'h0);
            chk("bp_data", 32'(out_data), 32'h43);
            chk("bp_count", 32'(xfer_count), saved);
        end
        out_ready = 1'b1; mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00005500;
        cycle();
        chk("bp_release_count", 32'(xfer_count), saved + 1);
        chk("bp_refill_valid", 32'(out_valid), 32'h1);
        chk("bp_refill_data", 32'(out_data), 32'h55);

        // Counter wrap and reset mid-stream
        in_data = 32'h43322110;
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 65536; k++) cycle();
        chk("wrap_pre", 32'(xfer_count), 32'd65535);
        cycle();
        chk("wrap_zero", 32'(xfer_count), 32'd0);
        chk("wrap_valid_held", 32'(out_valid), 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_count", 32'(xfer_count), 32'h0);
        cycle();
        chk("midrst_rr_ready", 32'(smp_ready), 32'b0001);
        chk("midrst_rr_sel", 32'(out_sel), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            reset     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised, registered N:1 multiplexer; successor to the two-input combinational mux.
- Generalises data width and channel count.
- Adds a per-channel valid/ready handshake, a one-entry output register, and two selection modes: fixed select, or round-robin arbitration among requesting channels.
- Sits between several producer streams and one consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts.
- xfer_count  output  16  count of completed output handshakes.

Behaviour:
- Reset: one clock with reset=1 sets:
  - out_valid=0, out_data=0, out_sel=0, xfer_count=0.
  - last_grant=CHANNELS-1, so channel 0 has first round-robin priority.
- Reset overrides all other activity in the same cycle. Data held mid-operation is discarded; no handshake is counted that cycle.
- load_en = !out_valid || out_ready. The register is refillable in the same cycle it drains.
- Grant (combinational), mode 0:
  - grant = sel.
  - sel >= CHANNELS grants nothing; all in_ready=0.
- Grant, mode 1:
  - Search channels last_grant+1, last_grant+2, … modulo CHANNELS.
  - The first channel with in_valid=1 wins.
  - No valid channel means no grant.
- in_ready[i] = load_en && grant valid && i==grant. All other bits are 0.
- in_ready does not depend on in_valid in mode 0. In mode 1 it follows the arbitration result.
- Input transfer on channel g when in_valid[g] && in_ready[g]. Next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1.
- Round-robin pointer: last_grant<=g only on an input transfer in mode 1. It is unchanged in mode 0 and on idle cycles.
- Output transfer when out_valid && out_ready:
  - xfer_count increments by 1, wrapping 65535 to 0.
  - If there is no input transfer the same cycle, out_valid<=0. out_data and out_sel hold their last values.
- Simultaneous output drain and input transfer: out_valid stays 1, new data is loaded, and xfer_count increments. Full throughput is one word per clock.
- Backpressure (out_valid=1, out_ready=0):
  - All in_ready=0.
  - out_data, out_sel and out_valid hold stable.
  - No arbitration state changes.
- Latency: input accept to out_valid is 1 clock.
- Changes to mode or sel take effect at the next grant evaluation. A word already held in the output register is unaffected.
- Fairness in mode 1: with all CHANNELS continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,…
- Data path is pure selection; no arithmetic on data. out_sel is zero-extended to SEL_W.

Test Plan:
- Reset then idle: assert reset 1 cycle with in_valid=4'b1111 -> out_valid=0, out_data=0, xfer_count=0, in_ready=0000 during reset cycle; in_ready=0001 in the next cycle (mode 1).
- Fixed select: mode=0, sel=2, in_data ch0..3 = 8'h10,8'h21,8'h32,8'h43, all valid, out_ready=1 -> in_ready=0100; one clock later out_data=8'h32, out_sel=2; xfer_count increments every cycle thereafter.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; xfer_count=7 after the 8th load, 8 one cycle later.
- Sparse requests: mode=1, in_valid=4'b1010, last grant 1 -> next grant 3, then 1, then 3; channels 0 and 2 never get in_ready.
- Backpressure: out_valid=1 with out_data=8'h43, out_ready=0 for 5 cycles while inputs change -> out_data stays 8'h43, in_ready=0000, xfer_count unchanged; raising out_ready gives one increment and a same-cycle refill.
- Reset mid-stream and wrap: preload xfer_count to 65535 via 65535 handshakes, one more -> 0. Assert reset while out_valid=1 -> out_valid=0 next cycle and round-robin restarts at channel 0.
